// File: rtl/ccx_ic_rr_if.sv
// Packed N-port memory request/response bundle. The master modport issues requests
// and the slave modport answers them, on the interconnect's master side and on its slave side.
interface ccx_ic_rr_if #(
   parameter int N  = 1,
   parameter int AW = 39,
   parameter int DW = 64
);
   logic [N-1:0]        req;
   logic [N-1:0]        rtype;
   logic [N*AW-1:0]     addr;
   logic [N-1:0]        wen;
   logic [N*DW/8-1:0]   strb;
   logic [N*DW-1:0]     wdata;
   logic [N*2-1:0]      prv;
   logic [N-1:0]        gnt;
   logic [N-1:0]        err;
   logic [N*DW-1:0]     rdata;

   modport master (
      output req, rtype, addr, wen, strb, wdata, prv,
      input  gnt, err, rdata
   );

   modport slave (
      input  req, rtype, addr, wen, strb, wdata, prv,
      output gnt, err, rdata
   );
endinterface

// File: rtl/ccx_ic_rr.sv
// N-master to M-slave interconnect: region decode, round-robin arbitration with request locking
// for each slave, and registered response routing. CCX_IC_PRV_CHECK_EN enables region privilege checks.
module ccx_ic_rr #(
   parameter int               NM          = 2,
   parameter int               NS          = 4,
   parameter int               AW          = 39,
   parameter int               DW          = 64,
   parameter logic [NS*AW-1:0] REGION_BASE = {NS{39'h0}},
   parameter logic [NS*AW-1:0] REGION_SIZE = {NS{39'hFFF}},
   parameter logic [NS*2-1:0]  REGION_PRV  = {NS{2'b00}}
) (
   input logic           g_clk,
   input logic           g_reset,
   ccx_ic_rr_if.slave    m_bus,
   ccx_ic_rr_if.master   s_bus
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = $clog2(NS + 1);
   localparam int BW = DW / 8;
   localparam logic [SW-1:0] DEC_ERR = SW'(NS);

   logic [NM-1:0]                 dec_err;
   logic [NM-1:0][SW-1:0]         tgt;
   logic [NS-1:0][NM-1:0]         cand;
   logic [NS-1:0]                 sel_v;
   logic [NS-1:0][IW-1:0]         sel;
   logic [NS-1:0]                 lock_v;
   logic [NS-1:0][IW-1:0]         lock_idx;
   logic [NS-1:0][IW-1:0]         ptr;
   logic [NS-1:0]                 lock_drop;
   logic [NM-1:0]                 rsp_v;
   logic [NM-1:0][SW-1:0]         rsp_src;

   function automatic logic region_hit(input logic [AW-1:0] a, input int i);
      logic [AW:0] lim;
      lim = {1'b0, REGION_BASE[i*AW +: AW]} + {1'b0, REGION_SIZE[i*AW +: AW]};
      return (a >= REGION_BASE[i*AW +: AW]) && ({1'b0, a} <= lim);
   endfunction

   // Walk regions from the top down so the lowest-index hit is the one that sticks.
   always_comb begin : decode
      dec_err = '1;
      tgt     = '0;
      for (int k = 0; k < NM; k++) begin
         for (int i = NS - 1; i >= 0; i--) begin
            if (region_hit(m_bus.addr[k*AW +: AW], i)) begin
               dec_err[k] = 1'b0;
               tgt[k]     = SW'(i);
            end
         end
`ifdef CCX_IC_PRV_CHECK_EN
         for (int i = 0; i < NS; i++) begin
            if (!dec_err[k] && tgt[k] == SW'(i) && m_bus.prv[k*2 +: 2] < REGION_PRV[i*2 +: 2])
               dec_err[k] = 1'b1;
         end
`endif
      end
   end

`ifndef CCX_IC_PRV_CHECK_EN
   logic unused_prv;
   assign unused_prv = ^REGION_PRV;
`endif

   always_comb begin : candidates
      cand = '0;
      for (int j = 0; j < NS; j++)
         for (int k = 0; k < NM; k++)
            cand[j][k] = m_bus.req[k] & ~g_reset & ~dec_err[k] & (tgt[k] == SW'(j));
   end

   // A locked selection only survives while that master keeps requesting this slave.
   always_comb begin : arbitrate
      logic locked;
      int   idx;
      locked = 1'b0;
      idx    = 0;
      sel_v  = '0;
      sel    = '0;
      for (int j = 0; j < NS; j++) begin
         locked = 1'b0;
         for (int k = 0; k < NM; k++) begin
            if (lock_v[j] && lock_idx[j] == IW'(k) && cand[j][k]) begin
               locked   = 1'b1;
               sel_v[j] = 1'b1;
               sel[j]   = IW'(k);
            end
         end
         if (!locked) begin
            for (int off = NM; off >= 1; off--) begin
               idx = (int'(ptr[j]) + off) % NM;
               if (cand[j][idx]) begin
                  sel_v[j] = 1'b1;
                  sel[j]   = IW'(idx);
               end
            end
         end
      end
   end

   always_comb begin : forward
      s_bus.req   = '0;
      s_bus.rtype = '0;
      s_bus.addr  = '0;
      s_bus.wen   = '0;
      s_bus.strb  = '0;
      s_bus.wdata = '0;
      s_bus.prv   = '0;
      for (int j = 0; j < NS; j++) begin
         for (int k = 0; k < NM; k++) begin
            if (sel_v[j] && sel[j] == IW'(k)) begin
               s_bus.req[j]             = 1'b1;
               s_bus.rtype[j]           = m_bus.rtype[k];
               s_bus.addr[j*AW +: AW]   = m_bus.addr[k*AW +: AW];
               s_bus.wen[j]             = m_bus.wen[k];
               s_bus.strb[j*BW +: BW]   = m_bus.strb[k*BW +: BW];
               s_bus.wdata[j*DW +: DW]  = m_bus.wdata[k*DW +: DW];
               s_bus.prv[j*2 +: 2]      = m_bus.prv[k*2 +: 2];
            end
         end
      end
   end

   // Decode errors are accepted locally; everything else inherits the slave's grant.
   always_comb begin : grant
      m_bus.gnt = '0;
      for (int k = 0; k < NM; k++) begin
         m_bus.gnt[k] = m_bus.req[k] & ~g_reset & dec_err[k];
         for (int j = 0; j < NS; j++)
            if (sel_v[j] && sel[j] == IW'(k) && s_bus.gnt[j])
               m_bus.gnt[k] = 1'b1;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         lock_v   <= '0;
         lock_idx <= '0;
         for (int j = 0; j < NS; j++)
            ptr[j] <= IW'(NM - 1);
         rsp_v    <= '0;
         rsp_src  <= '0;
      end else begin
         for (int j = 0; j < NS; j++) begin
            lock_v[j] <= sel_v[j] & ~s_bus.gnt[j];
            if (sel_v[j])
               lock_idx[j] <= sel[j];
            if (sel_v[j] && s_bus.gnt[j])
               ptr[j] <= sel[j];
         end
         rsp_v <= m_bus.gnt;
         for (int k = 0; k < NM; k++)
            if (m_bus.gnt[k])
               rsp_src[k] <= dec_err[k] ? DEC_ERR : tgt[k];
      end
   end

   always_comb begin : respond
      m_bus.rdata = '0;
      m_bus.err   = '0;
      for (int k = 0; k < NM; k++) begin
         if (rsp_v[k]) begin
            if (rsp_src[k] == DEC_ERR)
               m_bus.err[k] = 1'b1;
            for (int i = 0; i < NS; i++) begin
               if (rsp_src[k] == SW'(i)) begin
                  m_bus.rdata[k*DW +: DW] = s_bus.rdata[i*DW +: DW];
                  m_bus.err[k]            = s_bus.err[i];
               end
            end
         end
      end
   end

   always_comb begin : lock_watch
      lock_drop = '0;
      for (int j = 0; j < NS; j++)
         for (int k = 0; k < NM; k++)
            if (lock_v[j] && lock_idx[j] == IW'(k) && !m_bus.req[k])
               lock_drop[j] = 1'b1;
   end

   // A master that abandons a request its slave has not yet granted breaks the handshake.
   a_lock_hold: assert property (@(posedge g_clk) disable iff (g_reset) lock_drop == '0);

endmodule

// File: tb/tb_ccx_ic_rr.sv
// Directed bench for ccx_ic_rr: reset masking, rotation, locking, decode error,
// parallel and back-to-back traffic, error routing and the privilege option.
module tb_ccx_ic_rr;
   localparam int NM = 2;
   localparam int NS = 4;
   localparam int AW = 39;
   localparam int DW = 64;
   localparam logic [NS*AW-1:0] RB = {39'h40000000, 39'h20000, 39'h10000, 39'h0};
   localparam logic [NS*AW-1:0] RS = {39'hFFFF, 39'hFFFF, 39'hFFFF, 39'hFFF};
   localparam logic [NS*2-1:0]  RP = {2'b00, 2'b11, 2'b00, 2'b00};

   logic        g_clk = 1'b0;
   logic        g_reset;
   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          w;

   always #5 g_clk = ~g_clk;
   always @(posedge g_clk) cyc <= cyc + 1;

   ccx_ic_rr_if #(.N(NM), .AW(AW), .DW(DW)) m_bus ();
   ccx_ic_rr_if #(.N(NS), .AW(AW), .DW(DW)) s_bus ();

   ccx_ic_rr #(
      .NM(NM), .NS(NS), .AW(AW), .DW(DW),
      .REGION_BASE(RB), .REGION_SIZE(RS), .REGION_PRV(RP)
   ) dut (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .m_bus   (m_bus),
      .s_bus   (s_bus)
   );

   // Slave j returns {j+1, cycle count} so routing and timing are both visible.
   always_comb begin
      s_bus.rdata = '0;
      for (int j = 0; j < NS; j++)
         s_bus.rdata[j*DW +: DW] = {8'(j + 1), 56'(cyc)};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic drive(input int k, input logic req, input logic [AW-1:0] addr,
                        input logic wen, input logic [63:0] wdata);
      m_bus.req[k]             = req;
      m_bus.rtype[k]           = 1'b0;
      m_bus.addr[k*AW +: AW]   = addr;
      m_bus.wen[k]             = wen;
      m_bus.strb[k*8 +: 8]     = wen ? 8'hFF : 8'h00;
      m_bus.wdata[k*DW +: DW]  = wdata;
      m_bus.prv[k*2 +: 2]      = 2'b11;
   endtask

   function automatic logic [63:0] sdat(input int j);
      return {8'(j + 1), 56'(cyc)};
   endfunction

   initial begin
      g_reset   = 1'b1;
      s_bus.gnt = 4'b1111;
      s_bus.err = 4'b1000;
      drive(0, 1'b1, 39'h100, 1'b0, 64'h0);
      drive(1, 1'b1, 39'h200, 1'b0, 64'h0);

      repeat (3) begin
         tick();
         chk("rst_sreq", 64'(s_bus.req), 64'h0);
         chk("rst_mgnt", 64'(m_bus.gnt), 64'h0);
         chk("rst_merr", 64'(m_bus.err), 64'h0);
         chk("rst_rdata0", m_bus.rdata[0 +: DW], 64'h0);
      end

      // Release: master 0 wins slave 0 first, then master 1.
      g_reset = 1'b0;
      #1;
      chk("rel_gnt", 64'(m_bus.gnt), 64'h1);
      chk("rel_sreq", 64'(s_bus.req), 64'h1);
      chk("rel_err", 64'(m_bus.err), 64'h0);
      chk("rel_rdata", m_bus.rdata[0 +: DW], 64'h0);
      tick();
      chk("rel_rsp0", m_bus.rdata[0 +: DW], sdat(0));
      #1;
      chk("rel_gnt2", 64'(m_bus.gnt), 64'h2);
      tick();
      chk("rel_rsp1", m_bus.rdata[DW +: DW], sdat(0));

      // Contention on region 1: alternate 0,1,0,1.
      drive(0, 1'b1, 39'h10000, 1'b0, 64'h0);
      drive(1, 1'b1, 39'h10008, 1'b0, 64'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         w = i % 2;
         chk("rr_gnt", 64'(m_bus.gnt), (i % 2) ? 64'h2 : 64'h1);
         chk("rr_saddr", 64'(s_bus.addr[AW +: AW]), w ? 64'h10008 : 64'h10000);
         tick();
         chk("rr_rsp", m_bus.rdata[w*DW +: DW], sdat(1));
         chk("rr_idle", m_bus.rdata[(1-w)*DW +: DW], 64'h0);
      end

      // Lock: master 1 selected with no grant, master 0 joins; master 1 must keep the slave.
      drive(0, 1'b0, 39'h0, 1'b0, 64'h0);
      drive(1, 1'b1, 39'h10040, 1'b0, 64'h0);
      s_bus.gnt = 4'b1101;
      #1;
      chk("lk_sreq", 64'(s_bus.req), 64'h2);
      chk("lk_gnt0", 64'(m_bus.gnt), 64'h0);
      tick();
      drive(0, 1'b1, 39'h10080, 1'b0, 64'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("lk_saddr", 64'(s_bus.addr[AW +: AW]), 64'h10040);
         chk("lk_hold", 64'(m_bus.gnt), 64'h0);
         tick();
      end
      s_bus.gnt = 4'b1111;
      #1;
      chk("lk_first", 64'(m_bus.gnt), 64'h2);
      tick();
      drive(1, 1'b0, 39'h0, 1'b0, 64'h0);
      #1;
      chk("lk_next", 64'(m_bus.gnt), 64'h1);
      chk("lk_saddr2", 64'(s_bus.addr[AW +: AW]), 64'h10080);
      tick();
      drive(0, 1'b0, 39'h0, 1'b0, 64'h0);

      // Decode error: local grant, no slave request, error response.
      drive(0, 1'b1, 39'h7F00000000, 1'b0, 64'h0);
      #1;
      chk("de_gnt", 64'(m_bus.gnt), 64'h1);
      chk("de_sreq", 64'(s_bus.req), 64'h0);
      tick();
      chk("de_err", 64'(m_bus.err), 64'h1);
      chk("de_rdata", m_bus.rdata[0 +: DW], 64'h0);
      drive(0, 1'b0, 39'h0, 1'b0, 64'h0);

      // Parallel ROM read and RAM write, then back-to-back ROM read.
      drive(0, 1'b1, 39'h100, 1'b0, 64'h0);
      drive(1, 1'b1, 39'h20010, 1'b1, 64'hDEADBEEF01234567);
      #1;
      chk("par_gnt", 64'(m_bus.gnt), 64'h3);
      chk("par_sreq", 64'(s_bus.req), 64'h5);
      chk("par_swen", 64'(s_bus.wen), 64'h4);
      chk("par_strb", 64'(s_bus.strb[2*8 +: 8]), 64'hFF);
      chk("par_wdata", s_bus.wdata[2*DW +: DW], 64'hDEADBEEF01234567);
      tick();
      chk("par_rsp0", m_bus.rdata[0 +: DW], sdat(0));
      chk("par_err", 64'(m_bus.err), 64'h0);
      drive(1, 1'b0, 39'h0, 1'b0, 64'h0);
      drive(0, 1'b1, 39'h108, 1'b0, 64'h0);
      #1;
      chk("b2b_gnt", 64'(m_bus.gnt), 64'h1);
      chk("b2b_saddr", 64'(s_bus.addr[0 +: AW]), 64'h108);
      tick();
      chk("b2b_rsp", m_bus.rdata[0 +: DW], sdat(0));
      drive(0, 1'b0, 39'h0, 1'b0, 64'h0);

      // Slave error routed from MMIO region.
      drive(1, 1'b1, 39'h40000000, 1'b0, 64'h0);
      #1;
      chk("se_gnt", 64'(m_bus.gnt), 64'h2);
      tick();
      chk("se_err", 64'(m_bus.err), 64'h2);
      chk("se_rdata", m_bus.rdata[DW +: DW], sdat(3));
      drive(1, 1'b0, 39'h0, 1'b0, 64'h0);

      // Low-privilege access to region 2.
      drive(0, 1'b1, 39'h20000, 1'b0, 64'h0);
      m_bus.prv[1:0] = 2'b00;
      #1;
      chk("prv_gnt", 64'(m_bus.gnt), 64'h1);
`ifdef CCX_IC_PRV_CHECK_EN
      chk("prv_sreq", 64'(s_bus.req), 64'h0);
`else
      chk("prv_sreq", 64'(s_bus.req), 64'h4);
`endif
      tick();
`ifdef CCX_IC_PRV_CHECK_EN
      chk("prv_err", 64'(m_bus.err), 64'h1);
      chk("prv_rdata", m_bus.rdata[0 +: DW], 64'h0);
`else
      chk("prv_err", 64'(m_bus.err), 64'h0);
      chk("prv_rdata", m_bus.rdata[0 +: DW], sdat(2));
`endif
      drive(0, 1'b0, 39'h0, 1'b0, 64'h0);

      tick();
      chk("idle_gnt", 64'(m_bus.gnt), 64'h0);
      chk("idle_err", 64'(m_bus.err), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
